// File: rtl/uart_pkg.sv
// Purpose: shared UART constants: per-code bit periods, autobaud thresholds, detector state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Bit periods in clocks for each 2-bit rate select (shared with the baud generator).
  localparam int RATE0_PERIOD = 301;
  localparam int RATE1_PERIOD = 601;
  localparam int RATE2_PERIOD = 1201;
  localparam int RATE3_PERIOD = 2401;

  // Default autobaud measurement parameters.
  localparam int CNT_W_DEF    = 12;
  localparam int MIN_IDLE_DEF = 16;
  localparam int T_MIN_DEF    = 200;
  localparam int T_01_DEF     = 450;
  localparam int T_12_DEF     = 900;
  localparam int T_23_DEF     = 1800;
  localparam int T_MAX_DEF    = 3600;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    MEASURE   = 3'd2,
    CLASSIFY  = 3'd3,
    VERIFY    = 3'd4,
    WAIT_HIGH = 3'd5,
    LOCKED    = 3'd6
  } autobaud_state_e;

  // Bit period for a rate select, as used by the generator.
  function automatic int bit_period(input logic [1:0] code);
    case (code)
      2'd0:    bit_period = RATE0_PERIOD;
      2'd1:    bit_period = RATE1_PERIOD;
      2'd2:    bit_period = RATE2_PERIOD;
      default: bit_period = RATE3_PERIOD;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Purpose: two-flop synchroniser for an asynchronous line that idles high.
// Latency: 2 clocks from d to q.
// Backpressure: none.
module uart_sync2 (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values are a plain shift of the input through the two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Both stages come out of reset at the line's idle level so no false edge is seen.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_autobaud_detect.sv
// Purpose: recover the 2-bit rate select from the start-bit low time of a 0x55 sync character.
// Latency: lock/err registered the clock after classification; edge detect 3 clocks on both edges.
// Backpressure: none; arm is a single-cycle request, done/err are pulses. Option: UART_AUTOBAUD_VERIFY_EN.
module uart_autobaud_detect
  import uart_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MIN_IDLE = MIN_IDLE_DEF,
  parameter int T_MIN    = T_MIN_DEF,
  parameter int T_01     = T_01_DEF,
  parameter int T_12     = T_12_DEF,
  parameter int T_23     = T_23_DEF,
  parameter int T_MAX    = T_MAX_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rxd,
  input  logic       arm,
  output logic [1:0] rate_sel,
  output logic       locked,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_IDLE_C = CNT_W'(MIN_IDLE);
  localparam logic [CNT_W-1:0] T_MIN_C    = CNT_W'(T_MIN);
  localparam logic [CNT_W-1:0] T_01_C     = CNT_W'(T_01);
  localparam logic [CNT_W-1:0] T_12_C     = CNT_W'(T_12);
  localparam logic [CNT_W-1:0] T_23_C     = CNT_W'(T_23);
  localparam logic [CNT_W-1:0] T_MAX_C    = CNT_W'(T_MAX);

  autobaud_state_e  state_q, state_d;
  logic             rxs;
  logic             rxs_dly_q, rxs_dly_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] width_inc;
  logic [1:0]       rate_sel_q, rate_sel_d;
  logic             locked_q, locked_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             fall, rise;
`ifdef UART_AUTOBAUD_VERIFY_EN
  logic [CNT_W-1:0] w1_q, w1_d;
  logic             ver_low_q, ver_low_d;
  logic [CNT_W-1:0] w_diff;
  logic             w_match;
`endif

  // Map a measured width to its rate code; callers have already excluded W < T_MIN and W >= T_MAX.
  function automatic logic [1:0] code_of(input logic [CNT_W-1:0] w);
    code_of = 2'd3;
    if (w < T_23_C) code_of = 2'd2;
    if (w < T_12_C) code_of = 2'd1;
    if (w < T_01_C) code_of = 2'd0;
  endfunction

  uart_sync2 u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (rxd),
    .q       (rxs)
  );

  // Edges compare the synchronised line to its one-clock delayed copy; both edges see the same delay.
  assign fall      = rxs_dly_q & ~rxs;
  assign rise      = ~rxs_dly_q & rxs;
  assign width_inc = width_q + ONE_C;

`ifdef UART_AUTOBAUD_VERIFY_EN
  // Second low pulse must be within W1/8 of the start bit.
  assign w_diff  = (width_q > w1_q) ? (width_q - w1_q) : (w1_q - width_q);
  assign w_match = (w_diff <= (w1_q >> 3));
`endif

  // Next-state, counters and output pulses.
  always_comb begin
    state_d    = state_q;
    rxs_dly_d  = rxs;
    idle_cnt_d = idle_cnt_q;
    width_d    = width_q;
    rate_sel_d = rate_sel_q;
    locked_d   = locked_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef UART_AUTOBAUD_VERIFY_EN
    w1_d       = w1_q;
    ver_low_d  = ver_low_q;
`endif
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d    = ARMED;
          idle_cnt_d = '0;
        end
      end
      ARMED: begin
        // Only a falling edge preceded by enough idle-high time can start a measurement.
        if (fall && (idle_cnt_q == MIN_IDLE_C)) begin
          state_d    = MEASURE;
          width_d    = ONE_C;
          idle_cnt_d = '0;
        end else if (rxs) begin
          if (idle_cnt_q != MIN_IDLE_C) idle_cnt_d = idle_cnt_q + ONE_C;
        end else begin
          idle_cnt_d = '0;
        end
      end
      MEASURE: begin
        if (rise) begin
          state_d = CLASSIFY;
        end else begin
          width_d = width_inc;
          if (width_inc == T_MAX_C) begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      CLASSIFY: begin
        if (width_q < T_MIN_C) begin
          err_d   = 1'b1;
          state_d = ARMED;
        end else begin
`ifdef UART_AUTOBAUD_VERIFY_EN
          w1_d      = width_q;
          width_d   = '0;
          ver_low_d = 1'b0;
          state_d   = VERIFY;
`else
          rate_sel_d = code_of(width_q);
          locked_d   = 1'b1;
          done_d     = 1'b1;
          state_d    = LOCKED;
`endif
        end
      end
`ifdef UART_AUTOBAUD_VERIFY_EN
      VERIFY: begin
        if (!ver_low_q) begin
          // High gap before the second low pulse; too long means this was not a sync character.
          if (fall) begin
            ver_low_d = 1'b1;
            width_d   = ONE_C;
          end else begin
            width_d = width_inc;
            if (width_inc == T_MAX_C) begin
              err_d   = 1'b1;
              state_d = ARMED;
            end
          end
        end else if (rise) begin
          if (w_match) begin
            rate_sel_d = code_of(w1_q);
            locked_d   = 1'b1;
            done_d     = 1'b1;
            state_d    = LOCKED;
          end else begin
            err_d   = 1'b1;
            state_d = ARMED;
          end
        end else begin
          width_d = width_inc;
          if (width_inc == T_MAX_C) begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
`endif
      WAIT_HIGH: begin
        if (rxs) begin
          state_d    = ARMED;
          idle_cnt_d = '0;
        end
      end
      LOCKED: begin
        // Re-arm drops lock but keeps the last good rate on the select path.
        if (arm) begin
          locked_d   = 1'b0;
          idle_cnt_d = '0;
          state_d    = ARMED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any measurement in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rxs_dly_q  <= 1'b1;
      idle_cnt_q <= '0;
      width_q    <= '0;
      rate_sel_q <= 2'd0;
      locked_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxs_dly_q  <= rxs_dly_d;
      idle_cnt_q <= idle_cnt_d;
      width_q    <= width_d;
      rate_sel_q <= rate_sel_d;
      locked_q   <= locked_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef UART_AUTOBAUD_VERIFY_EN
  // Start-bit width and sub-phase of the verification pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w1_q      <= '0;
      ver_low_q <= 1'b0;
    end else begin
      w1_q      <= w1_d;
      ver_low_q <= ver_low_d;
    end
  end
`endif

  assign rate_sel = rate_sel_q;
  assign locked   = locked_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE) && (state_q != LOCKED);

endmodule

// File: tb/tb_uart_autobaud_detect.sv
// Purpose: randomized and directed check of uart_autobaud_detect against a width-classification model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_uart_autobaud_detect;

  localparam int T_MIN = 200;
  localparam int T_01  = 450;
  localparam int T_12  = 900;
  localparam int T_23  = 1800;
  localparam int T_MAX = 3600;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd     = 1'b1;
  logic       arm     = 1'b0;
  logic [1:0] rate_sel;
  logic       locked, done, err, busy;

  uart_autobaud_detect dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rxd      (rxd),
    .arm      (arm),
    .rate_sel (rate_sel),
    .locked   (locked),
    .done     (done),
    .err      (err),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // kind 0 = done, 1 = err; at = -1 means the cycle is not checked.
  typedef struct {int kind; int code; int at;} ev_t;
  ev_t expq[$];
  ev_t e;

  int checks = 0;
  int errors = 0;
  int exp_rate = 0;
  bit exp_locked = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference classification of one low width straight from the threshold table.
  function automatic int ref_code(input int w);
    if (w < T_MIN)  return -1;
    if (w >= T_MAX) return -2;
    if (w < T_01)   return 0;
    if (w < T_12)   return 1;
    if (w < T_23)   return 2;
    return 3;
  endfunction

  task automatic push_ev(input int kind, input int code, input int at);
    ev_t x;
    x.kind = kind; x.code = code; x.at = at;
    expq.push_back(x);
  endtask

  // Monitor: every done/err pulse is matched against the next expected event.
  always @(negedge clock) begin
    if (reset_n && (done || err)) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: done=%0b err=%0b rate_sel=%0d at cycle %0d, nothing expected",
                 done, err, rate_sel, cyc);
      end else begin
        e = expq.pop_front();
        chk("event_kind", {30'd0, done, err}, (e.kind == 0) ? 32'd2 : 32'd1);
        if (e.kind == 0) chk("event_code", rate_sel, e.code);
        if (e.at >= 0)   chk("event_cycle", cyc, e.at);
      end
    end
  end

  task automatic do_arm();
    @(negedge clock); arm = 1'b1;
    @(negedge clock); arm = 1'b0;
    if (exp_locked) begin
      chk("rearm_locked", locked, 0);
      chk("rearm_rate_hold", rate_sel, exp_rate);
      exp_locked = 1'b0;
    end
  endtask

  // Called at a negedge; drives rxd low for exactly l clock edges, optionally pulsing arm mid-way.
  task automatic low_pulse(input int l, input int arm_at);
    rxd = 1'b0;
    for (int i = 1; i <= l; i++) begin
      @(negedge clock);
      arm = (i == arm_at);
    end
    rxd = 1'b1;
    arm = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL event_missing: %0d expected event(s) never appeared by cycle %0d", expq.size(), cyc);
      expq.delete();
    end
  endtask

  // One sync character: idle high, start-bit low l1, and (verify build) high l1 then low l2.
  task automatic send_char(input int hi, input int l1, input int l2, input int arm_at);
    int code, c0, diff;
    rxd = 1'b1;
    repeat (hi) @(negedge clock);
    code = ref_code(l1);
    c0   = cyc + 1;
    if (code == -1) begin
      push_ev(1, 0, c0 + l1 + 3);
    end else if (code == -2) begin
      push_ev(1, 0, c0 + 1 + T_MAX);
    end else begin
`ifdef UART_AUTOBAUD_VERIFY_EN
      diff = (l2 > l1) ? l2 - l1 : l1 - l2;
      if (diff <= (l1 >> 3)) begin
        push_ev(0, code, -1);
        exp_rate = code; exp_locked = 1'b1;
      end else begin
        push_ev(1, 0, -1);
      end
`else
      diff = l2;
      push_ev(0, code, c0 + l1 + 3);
      exp_rate = code; exp_locked = 1'b1;
`endif
    end
    low_pulse(l1, arm_at);
`ifdef UART_AUTOBAUD_VERIFY_EN
    if (code >= 0) begin
      repeat (l1) @(negedge clock);
      low_pulse(l2, 0);
    end
`endif
    repeat (8) @(negedge clock);
    wait_drain();
    chk("locked_level", locked, exp_locked);
    chk("rate_sel_level", rate_sel, exp_rate);
    chk("busy_level", busy, !exp_locked);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi, l1, l2;
    repeat (3) @(negedge clock);
    chk("reset_rate_sel", rate_sel, 0);
    chk("reset_locked", locked, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_busy", busy, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_busy", busy, 0);
    chk("idle_locked", locked, 0);

    // Armed with the line stuck high: busy, no events.
    do_arm();
    repeat (10000) @(negedge clock);
    chk("stuck_high_busy", busy, 1);
    send_char(20, 601, 601, 0);

    // Reset in the middle of a measurement.
    do_arm();
    rxd = 1'b1;
    repeat (20) @(negedge clock);
    rxd = 1'b0;
    repeat (100) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("midreset_rate_sel", rate_sel, 0);
    chk("midreset_locked", locked, 0);
    chk("midreset_done", done, 0);
    chk("midreset_err", err, 0);
    chk("midreset_busy", busy, 0);
    rxd = 1'b1;
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    exp_rate = 0; exp_locked = 1'b0;

    // Codes and threshold boundaries.
    do_arm(); send_char(20, 2401, 2401, 0);
    do_arm(); send_char(20, 449, 449, 0);
    do_arm(); send_char(20, 450, 450, 0);
    do_arm(); send_char(20, 1799, 1799, 0);
    do_arm(); send_char(20, 199, 199, 0);
    send_char(20, 1201, 1201, 0);

    // Falling edge after too short an idle is ignored.
    do_arm();
    rxd = 1'b1;
    repeat (10) @(negedge clock);
    rxd = 1'b0;
    repeat (50) @(negedge clock);
    send_char(20, 1201, 1201, 0);

    // Timeout, then recovery on a valid pulse.
    do_arm(); send_char(20, 4000, 4000, 0);
    send_char(20, 301, 301, 0);

    // Re-arm from a code-2 lock, then arm during MEASURE is ignored.
    do_arm(); send_char(20, 1201, 1201, 0);
    do_arm(); send_char(20, 500, 500, 250);

`ifdef UART_AUTOBAUD_VERIFY_EN
    do_arm(); send_char(20, 601, 700, 0);
    do_arm(); send_char(20, 601, 660, 0);
`endif

    // Randomized widths across all classes.
    for (int k = 0; k < 8; k++) begin
      hi = 16 + int'($urandom_range(0, 30));
      l1 = int'($urandom_range(150, 3000));
      if (k == 7) l1 = int'($urandom_range(3590, 3700));
      l2 = l1 - l1 / 6 + int'($urandom_range(0, l1 / 3));
      if (l2 >= T_MAX) l2 = T_MAX - 1;
      do_arm();
      send_char(hi, l1, l2, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_autobaud_detect.md
Name: uart_autobaud_detect

Overview:
- Receive-side counterpart of the baud rate generator: the generator maps a 2-bit rate select to a bit period, and this block recovers that select from the bit period seen on the incoming serial line.
- Measures the start-bit low time of a sync character 0x55 on rxd and classifies it into one of four rate codes: 0 = 301, 1 = 601, 2 = 1201, 3 = 2401 clocks/bit.
- Drives rate_sel into the UART rate-select path and flags lock or error.

Parameters:
- CNT_W, 12, width of the low-time counter.
- MIN_IDLE, 16, synchronised-high clocks required before a falling edge is accepted.
- T_MIN, 200, measured width below this is a glitch (error).
- T_01, 450, boundary between code 0 and code 1.
- T_12, 900, boundary between code 1 and code 2.
- T_23, 1800, boundary between code 2 and code 3.
- T_MAX, 3600, width reaching this aborts as too slow (error).

Ports:
- clock, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- rxd, input, 1, asynchronous serial line; idle high.
- arm, input, 1, single-cycle request to start or restart detection.
- rate_sel, output, 2, detected rate code, same encoding as the generator's select.
- locked, output, 1, level; rate_sel is valid.
- done, output, 1, one-cycle pulse on successful lock.
- err, output, 1, one-cycle pulse on classification failure.
- busy, output, 1, high in any state other than IDLE and LOCKED.

Behaviour:
- Reset and clock (already decided): reset reset_n, asynchronous, active-low; clock clock.
- Reset values: rate_sel=0, locked=0, done=0, err=0, busy=0. State=IDLE, counters=0, synchroniser flops=1.
- rxd passes through a 2-flop synchroniser, rxs, before any use; edges are detected on rxs against its delayed copy. Total detect latency is 3 clocks, which is absorbed equally by both edges, so widths are exact.
- IDLE:
  - arm -> ARMED.
  - rxd is ignored.
- ARMED:
  - Idle counter counts consecutive rxs=1 clocks, saturating at MIN_IDLE; rxs=0 clears it.
  - A falling edge with the counter at MIN_IDLE -> MEASURE, width counter loaded with 1.
  - A falling edge before MIN_IDLE is ignored.
- MEASURE:
  - Width counter increments each clock that rxs=0.
  - Rising edge -> CLASSIFY.
  - If the width reaches T_MAX -> err pulse, go to WAIT_HIGH.
  - The counter can never wrap, because T_MAX < 2^CNT_W.
- CLASSIFY (one clock), with W = measured width:
  - W < T_MIN -> err pulse, return to ARMED.
  - T_MIN <= W < T_01 -> code 0.
  - T_01 <= W < T_12 -> code 1.
  - T_12 <= W < T_23 -> code 2.
  - T_23 <= W < T_MAX -> code 3.
  - On a valid code (and, with the optional feature, once verification passes): rate_sel is updated, locked=1, done pulses, state -> LOCKED. Lock is asserted the clock after CLASSIFY.
- WAIT_HIGH:
  - Waits for rxs=1, then -> ARMED with the idle counter cleared.
- LOCKED:
  - rate_sel and locked are held.
  - arm -> locked=0 on the next clock, rate_sel is held at its old value, state -> ARMED.
- arm in ARMED, MEASURE, CLASSIFY or WAIT_HIGH is ignored.
- err and done are never asserted in the same cycle.
- rate_sel changes only on a successful lock.
- Reset mid-measurement aborts immediately to reset values.

Optional Feature:
- Macro: UART_AUTOBAUD_VERIFY_EN.
- Defined:
  - After the start bit, 0x55 produces a high bit followed by a low bit.
  - CLASSIFY stores W1 and goes to VERIFY, which measures the next low pulse W2 using the same counter rules and T_MAX abort.
  - Lock only if |W2 - W1| <= W1>>3; otherwise err pulse -> ARMED.
  - A high gap between the two pulses reaching T_MAX -> err pulse -> ARMED.
- Undefined:
  - VERIFY state and its logic are absent; lock follows CLASSIFY directly.

Decomposition:
- Shared package uart_pkg holds:
  - per-code bit periods 301/601/1201/2401 (shared with the generator);
  - default thresholds T_MIN..T_MAX;
  - state encodings IDLE, ARMED, MEASURE, CLASSIFY, VERIFY, WAIT_HIGH, LOCKED.
- One sub-module: uart_sync2, the 2-flop synchroniser with reset value 1, reused by the UART receiver.

Test Plan:
- Reset checks:
  - Assert reset_n=0 mid-MEASURE -> all outputs 0 next edge, state IDLE.
  - arm with rxd stuck high 10000 clocks -> busy=1, no done or err.
- Lock at code 1:
  - arm, rxd high 20 clocks, low 601, high -> done pulse, locked=1, rate_sel=1.
  - Repeat with low 2401 -> rate_sel=3.
- Boundaries:
  - Low 449 -> rate_sel=0.
  - Low 450 -> rate_sel=1.
  - Low 1799 -> rate_sel=2.
  - Low 199 -> err, no lock, state ARMED.
- Edge qualification:
  - Falling edge after only 10 high clocks -> ignored.
  - Next valid 1201-clock low -> rate_sel=2.
- Timeout:
  - Low held 4000 clocks -> err exactly at width 3600.
  - No further err; then rxd high -> ARMED.
  - A valid 301 pulse -> rate_sel=0.
- Re-arm and verify:
  - From LOCKED (rate_sel=2), arm -> locked=0, rate_sel stays 2.
  - arm during MEASURE -> ignored.
  - With UART_AUTOBAUD_VERIFY_EN: pulses 601/700 -> err.
  - With UART_AUTOBAUD_VERIFY_EN: pulses 601/660 -> lock, rate_sel=1.
